// File: rtl/skew_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package : skew_buf_pkg
// Shared FSM state type, mode constants and lane-stage helper for skew_buffer.
// Rev     : 1.0
// ============================================================================
package skew_buf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_t;

  localparam logic SKEW_MODE_SKEW   = 1'b0;
  localparam logic SKEW_MODE_DESKEW = 1'b1;

  // Output stage index of a lane: skew gives lane i+1 stages, de-skew N-i stages.
  function automatic int unsigned lane_stage(input int unsigned lane,
                                             input int unsigned n,
                                             input logic        mode);
    return (mode == SKEW_MODE_DESKEW) ? (n - 1 - lane) : lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_lane.sv
`default_nettype none
// ============================================================================
// Module : skew_lane
// One lane's {valid, last, data} delay line; output tap chosen by depth_sel.
// Build option: SKEW_BUF_ZERO_FILL_EN zeroes data of stages loaded invalid.
// Rev    : 1.0
// ============================================================================
module skew_lane #(
  parameter  int MAX_DEPTH  = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int SEL_W      = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adv,
  input  logic [SEL_W-1:0]      depth_sel,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  logic [MAX_DEPTH-1:0]  r_valid;
  logic [MAX_DEPTH-1:0]  r_last;
  logic [DATA_WIDTH-1:0] r_data [MAX_DEPTH];
  logic [DATA_WIDTH-1:0] w_data_in;

`ifdef SKEW_BUF_ZERO_FILL_EN
  assign w_data_in = in_valid ? in_data : '0;
`else
  assign w_data_in = in_data;
`endif

  // The full chain always shifts; only the selected tap is observed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_last  <= '0;
      for (int s = 0; s < MAX_DEPTH; s++) begin
        r_data[s] <= '0;
      end
    end else if (adv) begin
      r_valid[0] <= in_valid;
      r_last[0]  <= in_valid & in_last;
      r_data[0]  <= w_data_in;
      for (int s = 1; s < MAX_DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_last[s]  <= r_last[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign out_valid = r_valid[depth_sel];
  assign out_data  = r_data[depth_sel];
  assign out_last  = r_last[depth_sel] & r_valid[depth_sel];

endmodule
`default_nettype wire

// File: rtl/skew_buffer.sv
`default_nettype none
// ============================================================================
// Module : skew_buffer
// N-lane systolic input skew / output de-skew stage with framing and backpressure.
// Build option: SKEW_BUF_ZERO_FILL_EN (see skew_lane).
// Rev    : 1.0
// ============================================================================
module skew_buffer #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic [N-1:0]            out_lane_valid,
  output logic                    out_last,
  output logic [LEN_WIDTH-1:0]    frame_len,
  output logic                    busy
);
  import skew_buf_pkg::*;

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  skew_state_t           r_state;
  logic                  r_mode_q;
  logic                  r_busy;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [LEN_WIDTH-1:0]  r_frame_len;

  logic                    w_adv;
  logic                    w_accept;
  logic                    w_out_valid;
  logic                    w_out_last;
  logic [N-1:0]            w_lane_valid;
  logic [N-1:0]            w_lane_last;
  logic [N-1:0]            w_last_mask;
  logic [N*DATA_WIDTH-1:0] w_lane_data;

  assign w_out_valid = |w_lane_valid;
  assign w_adv       = out_ready | ~w_out_valid;
  assign in_ready    = (r_state != DRAIN) & w_adv;
  assign w_accept    = in_valid & in_ready;

  // The last flag is observed on the deepest lane of the latched mode.
  assign w_last_mask = (r_mode_q == SKEW_MODE_DESKEW) ? N'(1) : (N'(1) << (N - 1));
  assign w_out_last  = |(w_lane_last & w_last_mask);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam int unsigned c_skew_sel   = lane_stage(gi, N, SKEW_MODE_SKEW);
    localparam int unsigned c_deskew_sel = lane_stage(gi, N, SKEW_MODE_DESKEW);

    logic [SEL_W-1:0] w_sel;
    assign w_sel = (r_mode_q == SKEW_MODE_DESKEW) ? SEL_W'(c_deskew_sel) : SEL_W'(c_skew_sel);

    skew_lane #(
      .MAX_DEPTH  (N),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .adv       (w_adv),
      .depth_sel (w_sel),
      .in_valid  (w_accept),
      .in_data   (in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .in_last   (in_last),
      .out_valid (w_lane_valid[gi]),
      .out_data  (w_lane_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .out_last  (w_lane_last[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mode_q    <= SKEW_MODE_SKEW;
      r_busy      <= 1'b0;
      r_count     <= '0;
      r_frame_len <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode_q <= mode;
            r_count  <= LEN_WIDTH'(1);
            r_busy   <= 1'b1;
            r_state  <= in_last ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_count <= r_count + LEN_WIDTH'(1);
            if (in_last) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_out_last && out_ready) begin
            r_frame_len <= r_count;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid      = w_out_valid;
  assign out_data       = w_lane_data;
  assign out_lane_valid = w_lane_valid;
  assign out_last       = w_out_last;
  assign frame_len      = r_frame_len;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_skew_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_skew_buffer
// Directed self-checking bench for skew_buffer (N=4, DATA_WIDTH=8).
// Rev    : 1.0
// ============================================================================
module tb_skew_buffer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_lane_valid;
  logic          out_last;
  logic [LW-1:0] frame_len;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skew_buffer #(.N(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .out_last       (out_last),
    .frame_len      (frame_len),
    .busy           (busy)
  );

  // Beat k carries 0x10*k + i on lane i.
  function automatic logic [N*DW-1:0] beat(input int k);
    logic [N*DW-1:0] b;
    for (int i = 0; i < N; i++) b[i*DW +: DW] = DW'(16 * k + i);
    return b;
  endfunction

  function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic test_reset();
    reset = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (frame_len !== '0) begin errors++; $display("FAIL reset_frame_len got=%0d exp=0", frame_len); end
    checks++; if (out_lane_valid !== '0) begin errors++; $display("FAIL reset_lane_valid got=%b exp=0", out_lane_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    reset = 1'b1;
  endtask

  // 4-beat frame without stalls; lane i delayed by i (skew) or N-1-i (de-skew).
  task automatic test_stream(input logic m);
    int d, k;
    logic ev;
    for (int c = -1; c <= 7; c++) begin
      @(negedge clk);
      in_valid = (c + 1 <= 3); in_data = beat(c + 1); in_last = (c + 1 == 3);
      mode = m; out_ready = 1'b1;
      #1;
      if (c >= 0) begin
        for (int i = 0; i < N; i++) begin
          d = m ? (N - 1 - i) : i;
          k = c - d;
          ev = (k >= 0 && k <= 3);
          checks++;
          if (out_lane_valid[i] !== ev) begin
            errors++; $display("FAIL stream_valid m=%0d c=%0d lane=%0d got=%b exp=%b", m, c, i, out_lane_valid[i], ev);
          end
          if (ev) begin
            checks++;
            if (lane(out_data, i) !== DW'(16 * k + i)) begin
              errors++; $display("FAIL stream_data m=%0d c=%0d lane=%0d got=%h exp=%h", m, c, i, lane(out_data, i), DW'(16 * k + i));
            end
          end
        end
        checks++;
        if (out_last !== (c == 6)) begin errors++; $display("FAIL stream_last m=%0d c=%0d got=%b exp=%b", m, c, out_last, (c == 6)); end
        checks++;
        if (in_ready !== (c <= 2 || c == 7)) begin errors++; $display("FAIL stream_in_ready m=%0d c=%0d got=%b exp=%b", m, c, in_ready, (c <= 2 || c == 7)); end
        checks++;
        if (busy !== (c <= 6)) begin errors++; $display("FAIL stream_busy m=%0d c=%0d got=%b exp=%b", m, c, busy, (c <= 6)); end
      end
    end
    checks++;
    if (frame_len !== LW'(4)) begin errors++; $display("FAIL stream_frame_len m=%0d got=%0d exp=4", m, frame_len); end
  endtask

  // out_ready low for edges 2..4; beat 2 offered but held off until edge 5.
  task automatic test_stall();
    int e, a, k, bi;
    logic ev, exp_rdy;
    for (int c = -1; c <= 10; c++) begin
      @(negedge clk);
      e = c + 1;
      bi = (e < 2) ? e : ((e <= 5) ? 2 : 3);
      in_valid = (e <= 6); in_data = beat(bi); in_last = (bi == 3);
      mode = 1'b0; out_ready = !(e >= 2 && e <= 4);
      #1;
      if (c >= 0) begin
        a = (c < 2) ? c : ((c <= 4) ? 1 : c - 3);
        for (int i = 0; i < N; i++) begin
          k = a - i;
          ev = (k >= 0 && k <= 3);
          checks++;
          if (out_lane_valid[i] !== ev) begin
            errors++; $display("FAIL stall_valid c=%0d lane=%0d got=%b exp=%b", c, i, out_lane_valid[i], ev);
          end
          if (ev) begin
            checks++;
            if (lane(out_data, i) !== DW'(16 * k + i)) begin
              errors++; $display("FAIL stall_data c=%0d lane=%0d got=%h exp=%h", c, i, lane(out_data, i), DW'(16 * k + i));
            end
          end
        end
        exp_rdy = !((e >= 2 && e <= 4) || (c >= 6 && c <= 9));
        checks++;
        if (in_ready !== exp_rdy) begin errors++; $display("FAIL stall_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
        checks++;
        if (out_last !== (c == 9)) begin errors++; $display("FAIL stall_last c=%0d got=%b exp=%b", c, out_last, (c == 9)); end
      end
    end
    checks++;
    if (frame_len !== LW'(4) || busy !== 1'b0) begin
      errors++; $display("FAIL stall_end frame_len=%0d busy=%b exp 4/0", frame_len, busy);
    end
  endtask

  // Mode flips after the first beat; frame keeps skew, next frame de-skews.
  task automatic test_mode_toggle();
    logic [N-1:0] em;
    for (int c = -1; c <= 6; c++) begin
      @(negedge clk);
      in_valid = (c + 1 <= 3); in_data = beat(c + 1); in_last = (c + 1 == 3);
      mode = (c + 1 == 0) ? 1'b0 : 1'b1; out_ready = 1'b1;
      #1;
      if (c >= 0) begin
        for (int i = 0; i < N; i++) em[i] = (c - i >= 0 && c - i <= 3);
        checks++;
        if (out_lane_valid !== em) begin errors++; $display("FAIL toggle_valid c=%0d got=%b exp=%b", c, out_lane_valid, em); end
        checks++;
        if (out_last !== (c == 6)) begin errors++; $display("FAIL toggle_last c=%0d got=%b exp=%b", c, out_last, (c == 6)); end
        if (c == 3 || c == 6) begin
          checks++;
          if (lane(out_data, 3) !== DW'(16 * (c - 3) + 3)) begin
            errors++; $display("FAIL toggle_lane3 c=%0d got=%h exp=%h", c, lane(out_data, 3), DW'(16 * (c - 3) + 3));
          end
        end
      end
    end
    // Back-to-back: first beat of the next frame in the cycle after the handshake.
    @(negedge clk);
    in_valid = 1'b1; in_data = beat(5); in_last = 1'b1; mode = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_ready in_ready=%b busy=%b exp 1/0", in_ready, busy); end
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0; mode = 1'b0;
      #1;
      em = (c <= 3) ? (N'(8) >> c) : '0;
      checks++;
      if (out_lane_valid !== em) begin errors++; $display("FAIL deskew2_valid c=%0d got=%b exp=%b", c, out_lane_valid, em); end
      checks++;
      if (out_last !== (c == 3)) begin errors++; $display("FAIL deskew2_last c=%0d got=%b exp=%b", c, out_last, (c == 3)); end
      if (c == 3) begin
        checks++;
        if (lane(out_data, 0) !== 8'h50) begin errors++; $display("FAIL deskew2_lane0 got=%h exp=50", lane(out_data, 0)); end
      end
    end
    checks++;
    if (frame_len !== LW'(1)) begin errors++; $display("FAIL deskew2_frame_len got=%0d exp=1", frame_len); end
  endtask

  // in_valid low for edges 2 and 3; beats accepted on edges 0,1,4,5.
  task automatic test_gaps();
    int e, k, src;
    logic ev;
    for (int c = -1; c <= 9; c++) begin
      @(negedge clk);
      e = c + 1;
      in_valid = (e == 0 || e == 1 || e == 4 || e == 5);
      in_data = beat((e < 2) ? e : e - 2); in_last = (e == 5);
      mode = 1'b0; out_ready = 1'b1;
      #1;
      if (c >= 0) begin
        for (int i = 0; i < N; i++) begin
          src = c - i;
          k = (src == 0 || src == 1) ? src : ((src == 4 || src == 5) ? src - 2 : -1);
          ev = (k >= 0);
          checks++;
          if (out_lane_valid[i] !== ev) begin
            errors++; $display("FAIL gap_valid c=%0d lane=%0d got=%b exp=%b", c, i, out_lane_valid[i], ev);
          end
          if (ev) begin
            checks++;
            if (lane(out_data, i) !== DW'(16 * k + i)) begin
              errors++; $display("FAIL gap_data c=%0d lane=%0d got=%h exp=%h", c, i, lane(out_data, i), DW'(16 * k + i));
            end
          end
`ifdef SKEW_BUF_ZERO_FILL_EN
          else begin
            checks++;
            if (lane(out_data, i) !== 8'h00) begin
              errors++; $display("FAIL gap_zero c=%0d lane=%0d got=%h exp=00", c, i, lane(out_data, i));
            end
          end
`endif
        end
        checks++;
        if (out_last !== (c == 8)) begin errors++; $display("FAIL gap_last c=%0d got=%b exp=%b", c, out_last, (c == 8)); end
      end
    end
    checks++;
    if (frame_len !== LW'(4)) begin errors++; $display("FAIL gap_frame_len got=%0d exp=4", frame_len); end
  endtask

  // Reset lands while the frame drains; a fresh 1-beat frame follows.
  task automatic test_reset_drain();
    logic [N-1:0] em;
    for (int c = -1; c <= 3; c++) begin
      @(negedge clk);
      in_valid = (c + 1 <= 3); in_data = beat(c + 1); in_last = (c + 1 == 3);
      mode = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL drain_state busy=%b in_ready=%b exp 1/0", busy, in_ready); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; in_data = beat(10); in_last = 1'b1; mode = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_drain_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_drain_busy got=%b exp=0", busy); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_drain_out_last got=%b exp=0", out_last); end
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      em = (c <= 3) ? (N'(1) << c) : '0;
      checks++;
      if (out_lane_valid !== em) begin errors++; $display("FAIL rst_frame_valid c=%0d got=%b exp=%b", c, out_lane_valid, em); end
      if (c <= 3) begin
        checks++;
        if (lane(out_data, c) !== DW'(8'hA0 + c)) begin
          errors++; $display("FAIL rst_frame_data c=%0d got=%h exp=%h", c, lane(out_data, c), DW'(8'hA0 + c));
        end
      end
      checks++;
      if (out_last !== (c == 3)) begin errors++; $display("FAIL rst_frame_last c=%0d got=%b exp=%b", c, out_last, (c == 3)); end
    end
    checks++;
    if (frame_len !== LW'(1) || busy !== 1'b0) begin
      errors++; $display("FAIL rst_frame_end frame_len=%0d busy=%b exp 1/0", frame_len, busy);
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_stall();
    test_mode_toggle();
    test_gaps();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
